// File: rtl/reg_skid_pkg.sv
// reg_skid_pkg: state encoding and occupancy constants shared by the reg_skid_dr slice
package reg_skid_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_t;
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;
endpackage

// File: rtl/reg_skid_dr_if.sv
// reg_skid_dr_if: ready/valid bus of reg_skid_dr; FLUSH exists only when REG_SKID_FLUSH_EN is defined
interface reg_skid_dr_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] IN_D;
  logic [WIDTH-1:0] OUT_Q;
  logic             IN_VALID;
  logic             IN_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [1:0]       COUNT;
`ifdef REG_SKID_FLUSH_EN
  logic             FLUSH;
  modport master (output IN_D, IN_VALID, OUT_READY, FLUSH, input IN_READY, OUT_Q, OUT_VALID, COUNT);
  modport slave  (input IN_D, IN_VALID, OUT_READY, FLUSH, output IN_READY, OUT_Q, OUT_VALID, COUNT);
`else
  modport master (output IN_D, IN_VALID, OUT_READY, input IN_READY, OUT_Q, OUT_VALID, COUNT);
  modport slave  (input IN_D, IN_VALID, OUT_READY, output IN_READY, OUT_Q, OUT_VALID, COUNT);
`endif
endinterface

// File: rtl/reg_skid_slot.sv
// reg_skid_slot: load-enable data register with asynchronous active-low reset to RST_DATA
module reg_skid_slot #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             CLK,
  input  logic             RES_N,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) q <= RST_DATA;
    else if (en) q <= d;
endmodule

// File: rtl/reg_skid_dr.sv
// reg_skid_dr: two-entry skid pipeline register with registered IN_READY; optional FLUSH via REG_SKID_FLUSH_EN
module reg_skid_dr import reg_skid_pkg::*; #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic          CLK,
  input  logic          RES_N,
  reg_skid_dr_if.slave  bus
);
  skid_state_t      st_q, st_d;
  logic             rdy_q, in_fire, out_fire, flush, main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;
`ifdef REG_SKID_FLUSH_EN
  assign flush = bus.FLUSH;
`else
  assign flush = 1'b0;
`endif
  assign in_fire  = bus.IN_VALID & rdy_q;
  assign out_fire = (st_q != EMPTY) & bus.OUT_READY;
  always_comb begin
    st_d    = flush ? EMPTY :
              st_q == EMPTY ? (in_fire ? ONE : EMPTY) :
              st_q == ONE   ? (in_fire & !out_fire ? FULL : !in_fire & out_fire ? EMPTY : ONE) :
              (out_fire ? ONE : FULL);
    main_en = flush | (in_fire & ((st_q == EMPTY) | ((st_q == ONE) & out_fire))) | ((st_q == FULL) & out_fire);
    main_d  = flush ? RST_DATA : st_q == FULL ? skid_q : bus.IN_D;
    skid_en = flush | ((st_q == ONE) & in_fire & !out_fire);
    skid_d  = flush ? RST_DATA : bus.IN_D;
  end
  // IN_READY looks one state ahead so it never depends combinationally on OUT_READY
  always_ff @(posedge CLK or negedge RES_N)
    if (!RES_N) begin
      st_q  <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      rdy_q <= st_d != FULL;
    end
  reg_skid_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_main (
    .CLK(CLK), .RES_N(RES_N), .en(main_en), .d(main_d), .q(main_q)
  );
  reg_skid_slot #(.WIDTH(WIDTH), .RST_DATA(RST_DATA)) u_skid (
    .CLK(CLK), .RES_N(RES_N), .en(skid_en), .d(skid_d), .q(skid_q)
  );
  assign bus.IN_READY  = rdy_q;
  assign bus.OUT_VALID = st_q != EMPTY;
  assign bus.OUT_Q     = main_q;
  assign bus.COUNT     = st_q == FULL ? CNT_FULL : st_q == ONE ? CNT_ONE : CNT_EMPTY;
endmodule

// File: tb/tb_reg_skid_dr.sv
// tb_reg_skid_dr: queue-model checked bench for reg_skid_dr; flush scenario runs when REG_SKID_FLUSH_EN is defined
module tb_reg_skid_dr;
  localparam logic [31:0] RST = 32'h0BAD_F00D;
  logic CLK = 1'b0;
  logic RES_N;
  reg_skid_dr_if #(.WIDTH(32)) bus ();
  reg_skid_dr #(.WIDTH(32), .RST_DATA(RST)) dut (.CLK(CLK), .RES_N(RES_N), .bus(bus));
  always #5 CLK = ~CLK;
  int checks = 0, failures = 0, edges = 0;
  logic [31:0] q[$], got[$], sent[$];
  bit mrdy = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: the stage is a FIFO of depth two whose ready is known one edge ahead
  always @(posedge CLK or negedge RES_N) begin
    bit inf, outf, fl;
    if (!RES_N) begin
      q.delete();
      mrdy = 1'b0;
    end else begin
`ifdef REG_SKID_FLUSH_EN
      fl = bus.FLUSH;
`else
      fl = 1'b0;
`endif
      inf  = bus.IN_VALID & mrdy;
      outf = (q.size() != 0) & bus.OUT_READY;
      if (fl) begin
        q.delete();
        mrdy = 1'b1;
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(bus.IN_D);
        mrdy = q.size() < 2;
      end
    end
  end
  always @(posedge CLK)
    if (RES_N && bus.OUT_VALID && bus.OUT_READY) got.push_back(bus.OUT_Q);
  always @(negedge CLK) begin
    chk("out_valid", {31'd0, bus.OUT_VALID}, {31'd0, q.size() != 0});
    chk("count", {30'd0, bus.COUNT}, q.size());
    chk("in_ready", {31'd0, bus.IN_READY}, {31'd0, mrdy});
    chk("ready_when_full", {31'd0, bus.IN_READY & (bus.COUNT == 2'd2)}, 32'd0);
    if (q.size() != 0) chk("out_q", bus.OUT_Q, q[0]);
  end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [31:0] d);
    bit r;
    bus.IN_D = d;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = bus.IN_READY;
      step();
      edges++;
      if (r) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask
  initial begin
    bit r, pend;
    int n, bad;
    RES_N = 1'b0;
    bus.IN_D = '0;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b0;
`ifdef REG_SKID_FLUSH_EN
    bus.FLUSH = 1'b0;
`endif
    repeat (3) step();
    chk("reset_out_q", bus.OUT_Q, RST);
    @(negedge CLK);
    #1 RES_N = 1'b1;
    #1 chk("ready_before_edge", {31'd0, bus.IN_READY}, 32'd0);
    step();
    chk("ready_after_edge", {31'd0, bus.IN_READY}, 32'd1);
    repeat (3) step();
    // streaming
    bus.OUT_READY = 1'b1;
    edges = 0;
    got.delete();
    for (int i = 1; i <= 16; i++) begin
      send(i);
      chk("stream_count", {30'd0, bus.COUNT}, 32'd1);
    end
    bus.IN_VALID = 1'b0;
    chk("stream_edges", edges, 32'd16);
    repeat (2) step();
    chk("stream_size", got.size(), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("stream_word", got[i], i + 1);
    // fill while blocked, then drain
    bus.OUT_READY = 1'b0;
    send(32'hA5A5_A5A5);
    send(32'h5A5A_5A5A);
    chk("full_count", {30'd0, bus.COUNT}, 32'd2);
    chk("full_ready", {31'd0, bus.IN_READY}, 32'd0);
    chk("full_q", bus.OUT_Q, 32'hA5A5_A5A5);
    bus.IN_D = 32'hDEAD_BEEF;
    repeat (3) step();
    chk("held_count", {30'd0, bus.COUNT}, 32'd2);
    chk("held_q", bus.OUT_Q, 32'hA5A5_A5A5);
    got.delete();
    bus.OUT_READY = 1'b1;
    send(32'hDEAD_BEEF);
    bus.IN_VALID = 1'b0;
    repeat (4) step();
    chk("drain_size", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("drain0", got[0], 32'hA5A5_A5A5);
      chk("drain1", got[1], 32'h5A5A_5A5A);
      chk("drain2", got[2], 32'hDEAD_BEEF);
    end
    // random traffic
    got.delete();
    sent.delete();
    pend = 1'b0;
    n = 0;
    for (int c = 0; c < 60000 && n < 10000; c++) begin
      if (!pend) begin
        if ($urandom_range(1) == 1) begin
          bus.IN_D = $urandom;
          bus.IN_VALID = 1'b1;
          pend = 1'b1;
        end else bus.IN_VALID = 1'b0;
      end
      bus.OUT_READY = $urandom_range(1) == 1;
      r = bus.IN_READY;
      step();
      if (pend && r) begin
        sent.push_back(bus.IN_D);
        pend = 1'b0;
        n++;
      end
    end
    chk("random_sent", n, 32'd10000);
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    repeat (4) step();
    chk("random_recv", got.size(), sent.size());
    bad = 0;
    for (int i = 0; i < sent.size() && i < got.size(); i++) if (got[i] !== sent[i]) bad++;
    chk("random_order", bad, 32'd0);
    // asynchronous reset while full
    bus.OUT_READY = 1'b0;
    send(32'h1111_1111);
    send(32'h2222_2222);
    bus.IN_VALID = 1'b0;
    chk("pre_reset_count", {30'd0, bus.COUNT}, 32'd2);
    #2 RES_N = 1'b0;
    #1;
    chk("async_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("async_count", {30'd0, bus.COUNT}, 32'd0);
    chk("async_ready", {31'd0, bus.IN_READY}, 32'd0);
    chk("async_q", bus.OUT_Q, RST);
    @(negedge CLK);
    #1 RES_N = 1'b1;
    step();
`ifdef REG_SKID_FLUSH_EN
    send(32'h3333_3333);
    send(32'h4444_4444);
    chk("pre_flush_count", {30'd0, bus.COUNT}, 32'd2);
    bus.IN_D = 32'h7777_7777;
    bus.IN_VALID = 1'b1;
    bus.OUT_READY = 1'b1;
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    bus.IN_VALID = 1'b0;
    chk("flush_count", {30'd0, bus.COUNT}, 32'd0);
    chk("flush_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    chk("flush_q", bus.OUT_Q, RST);
    chk("flush_ready", {31'd0, bus.IN_READY}, 32'd1);
    repeat (3) step();
    chk("flush_no_word", {31'd0, bus.OUT_VALID}, 32'd0);
`endif
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
